// File: rtl/sram_burst_reader.sv
// AXI4 INCR read-burst master: splits a (byte address, word count) command into
// 4 KB-safe bursts and streams the returned words through a credit-checked FIFO.
module sram_burst_reader #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]  cmd_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] SRAM_ARADDR,
    output logic [3:0]            SRAM_ARID,
    output logic                  SRAM_ARVALID,
    input  logic                  SRAM_ARREADY,
    output logic [7:0]            SRAM_ARLEN,
    output logic [2:0]            SRAM_ARSIZE,
    output logic [1:0]            SRAM_ARBURST,
    input  logic [DATA_WIDTH-1:0] SRAM_RDATA,
    input  logic [1:0]            SRAM_RRESP,
    input  logic                  SRAM_RVALID,
    output logic                  SRAM_RREADY,
    input  logic [3:0]            SRAM_RID,
    input  logic                  SRAM_RLAST
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned BEAT_W = 9;

    typedef enum logic [2:0] {IDLE, WAIT_SPACE, ADDR, DATA, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [CNT_WIDTH-1:0]    remaining;
    logic [BEAT_W-1:0]       beats;
    logic [BEAT_W-1:0]       beat_left;

    logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [FCNT_W-1:0]       count;

    logic [CNT_WIDTH-1:0]    want_c;
    logic [12:0]             gap_c;
    logic [10:0]             room_c;
    logic [BEAT_W-1:0]       beats_c;
    logic                    fits_c;
    logic                    push_c;
    logic                    pop_c;
    logic                    final_beat_c;
    logic                    last_tag_c;
    logic [FCNT_W-1:0]       count_after_pop_c;
    logic [FCNT_W-1:0]       count_next_c;
    logic [PTR_W-1:0]        rd_ptr_next_c;
    logic [DATA_WIDTH:0]     head_c;
    logic                    unused_ok;

    assign SRAM_ARID    = 4'h0;
    assign SRAM_ARSIZE  = 3'b010;
    assign SRAM_ARBURST = 2'b01;
    assign unused_ok    = ^{SRAM_RID, SRAM_RRESP[0], cmd_addr[1:0]};

    // Burst sizing: remaining words, MAX_BURST, and words left before the 4 KB page end.
    assign want_c  = (remaining < CNT_WIDTH'(MAX_BURST)) ? remaining : CNT_WIDTH'(MAX_BURST);
    assign gap_c   = 13'd4096 - 13'(addr[11:0]);
    assign room_c  = gap_c[12:2];
    assign beats_c = (32'(want_c) < 32'(room_c)) ? BEAT_W'(want_c) : BEAT_W'(room_c);
    assign fits_c  = (32'(count) + 32'(beats_c)) <= FIFO_DEPTH;

    assign push_c       = (state == DATA) && SRAM_RVALID && SRAM_RREADY;
    assign pop_c        = out_valid && out_ready;
    assign final_beat_c = (beat_left == BEAT_W'(1));
    assign last_tag_c   = (remaining == CNT_WIDTH'(1));

    assign count_after_pop_c = count - FCNT_W'(pop_c);
    assign count_next_c      = count_after_pop_c + FCNT_W'(push_c);
    assign rd_ptr_next_c     = rd_ptr + PTR_W'(pop_c);
    // An incoming beat into an otherwise empty FIFO becomes the head directly.
    assign head_c = (push_c && (count_after_pop_c == '0)) ? {last_tag_c, SRAM_RDATA}
                                                          : mem[rd_ptr_next_c];

    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr] <= {last_tag_c, SRAM_RDATA};
        end
    end

    // FIFO pointers and registered head
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_next_c;
            count     <= count_next_c;
            out_valid <= (count_next_c != '0);
            if (count_next_c != '0) begin
                {out_last, out_data} <= head_c;
            end
        end
    end

    // Command / burst sequencer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            SRAM_ARVALID <= 1'b0;
            SRAM_ARADDR  <= '0;
            SRAM_ARLEN   <= '0;
            SRAM_RREADY  <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            addr         <= '0;
            remaining    <= '0;
            beats        <= '0;
            beat_left    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr      <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                        remaining <= cmd_len;
                        err       <= 1'b0;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            state     <= WAIT_SPACE;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (fits_c) begin
                        beats        <= beats_c;
                        SRAM_ARADDR  <= addr;
                        SRAM_ARLEN   <= 8'(beats_c - BEAT_W'(1));
                        SRAM_ARVALID <= 1'b1;
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    if (SRAM_ARREADY) begin
                        SRAM_ARVALID <= 1'b0;
                        SRAM_RREADY  <= 1'b1;
                        beat_left    <= beats;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (push_c) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        beat_left <= beat_left - BEAT_W'(1);
                        // Beat count is authoritative; RLAST only flags protocol errors.
                        if (SRAM_RRESP[1] || (SRAM_RLAST != final_beat_c)) begin
                            err <= 1'b1;
                        end
                        if (final_beat_c) begin
                            SRAM_RREADY <= 1'b0;
                            addr        <= addr + ADDR_WIDTH'({beats, 2'b00});
                            state       <= last_tag_c ? DRAIN : WAIT_SPACE;
                        end
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Randomized scoreboard bench for sram_burst_reader with a behavioural SRAM responder.
module tb_sram_burst_reader;

    typedef struct {
        logic [31:0] addr;
        int          beats;
    } burst_t;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;
    logic        err;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic        ar_valid;
    logic        ar_ready;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready;
    logic [3:0]  r_id;
    logic        r_last;

    sram_burst_reader dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .err(err),
        .SRAM_ARADDR(ar_addr), .SRAM_ARID(ar_id), .SRAM_ARVALID(ar_valid), .SRAM_ARREADY(ar_ready),
        .SRAM_ARLEN(ar_len), .SRAM_ARSIZE(ar_size), .SRAM_ARBURST(ar_burst),
        .SRAM_RDATA(r_data), .SRAM_RRESP(r_resp), .SRAM_RVALID(r_valid), .SRAM_RREADY(r_ready),
        .SRAM_RID(r_id), .SRAM_RLAST(r_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          words = 0;
    int          r_cnt = 0;
    int          ar_cnt = 0;
    int          beat_idx = 0;
    int          rresp_beat = -1;
    int          rlast_beat = -1;
    bit          fast = 1'b0;
    bit          hold = 1'b0;
    bit          r_taken = 1'b0;
    logic [31:0] seed = 32'h1234_5678;

    burst_t      exp_ar[$];
    burst_t      bq[$];
    logic [32:0] exp_w[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic abort(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", name, $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // SRAM responder and consumer: inputs change 1 time unit after the rising edge
    always @(posedge clock) begin
        #1;
        if (reset) begin
            r_valid  = 1'b0;
            ar_ready = 1'b0;
            r_taken  = 1'b0;
        end else begin
            ar_ready = fast ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (!(r_valid && !r_taken)) begin
                r_taken = 1'b0;
                if (bq.size() > 0 && (fast || $urandom_range(0, 3) != 0)) begin
                    r_data  = word_at(bq[0].addr + 32'(4 * beat_idx));
                    r_last  = (beat_idx == bq[0].beats - 1) || (r_cnt == rlast_beat);
                    r_resp  = (r_cnt == rresp_beat) ? 2'b10 : 2'b00;
                    r_id    = 4'($urandom);
                    r_valid = 1'b1;
                end else begin
                    r_valid = 1'b0;
                end
            end
            out_ready = hold ? 1'b0 : (fast ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
    end

    // Monitor: samples on the falling edge, the handshakes it sees complete on the next rise
    always @(negedge clock) begin
        bit ar_hs, r_hs, pop;
        burst_t e;
        logic [32:0] w;
        if (reset) begin
            bq.delete();
            words    = 0;
            beat_idx = 0;
        end else begin
            ar_hs = ar_valid && ar_ready;
            r_hs  = r_valid && r_ready;
            pop   = out_valid && out_ready;
            check("out_valid_vs_model", out_valid, words > 0);
            check("rready_in_burst", r_ready, bq.size() > 0);
            if (exp_ar.size() == 0) check("arvalid_unexpected", ar_valid, 1'b0);
            if (ar_hs && exp_ar.size() > 0) begin
                e = exp_ar.pop_front();
                check("ar_addr", ar_addr, e.addr);
                check("ar_len", ar_len, 8'(e.beats - 1));
                check("ar_const", {ar_id, ar_size, ar_burst}, {4'h0, 3'b010, 2'b01});
                check("ar_outstanding", bq.size(), 0);
                bq.push_back('{ar_addr, int'(ar_len) + 1});
                ar_cnt++;
            end
            if (r_hs && bq.size() > 0) begin
                r_taken = 1'b1;
                r_cnt++;
                beat_idx++;
                if (beat_idx == bq[0].beats) begin
                    void'(bq.pop_front());
                    beat_idx = 0;
                end
            end
            if (pop) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: got %0h expected none", out_data);
                end else begin
                    w = exp_w.pop_front();
                    check("out_data", out_data, w[31:0]);
                    check("out_last", out_last, w[32]);
                end
            end
            words = words + int'(r_hs) - int'(pop);
            if (done) done_cnt++;
        end
    end

    task automatic prepare(input logic [31:0] a, input int len, input bit f,
                           input int rr, input int rl, input bit h);
        logic [31:0] cur;
        int rem, b, room;
        fast = f; rresp_beat = rr; rlast_beat = rl; hold = h;
        seed = $urandom; r_cnt = 0; ar_cnt = 0;
        cur = a & ~32'h3;
        for (int i = 0; i < len; i++) exp_w.push_back({i == len - 1, word_at(cur + 32'(4 * i))});
        rem = len;
        while (rem > 0) begin
            room = (4096 - int'(cur[11:0])) / 4;
            b = (rem < 16) ? rem : 16;
            if (room < b) b = room;
            exp_ar.push_back('{cur, b});
            cur = cur + 32'(4 * b);
            rem = rem - b;
        end
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = 16'(len);
        @(negedge clock);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(negedge clock);
        if (len != 0) check("cmd_ready_busy", cmd_ready, 1'b0);
        check("err_cleared", err, 1'b0);
    endtask

    task automatic run_cmd(input logic [31:0] a, input int len, input bit f,
                           input int rr, input int rl, input bit h);
        bit err_exp;
        int d0;
        bit seen;
        err_exp = (rr >= 0 && rr < len) || (rl >= 0 && rl < len);
        d0 = done_cnt;
        prepare(a, len, f, rr, rl, h);
        if (h) begin
            repeat (300) @(negedge clock);
            #1;
            check("hold_beats", r_cnt, 32);
            check("hold_ars", ar_cnt, 2);
            check("hold_fifo_words", words, 32);
            hold = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clock); #1;
            seen = (done_cnt != d0);
        end
        if (!seen) abort("wait_done");
        check("err", err, err_exp);
        check("words_left", exp_w.size(), 0);
        check("ars_left", exp_ar.size(), 0);
        check("beats_total", r_cnt, len);
        @(negedge clock);
        check("done_pulse_width", done, 1'b0);
        repeat (3) @(negedge clock);
        #1;
        check("done_count", done_cnt - d0, 1);
        check("cmd_ready_after", cmd_ready, 1'b1);
        check("err_sticky", err, err_exp);
    endtask

    task automatic reset_mid_burst();
        bit reached;
        prepare(32'h8000_4000, 40, 1'b0, -1, -1, 1'b0);
        reached = 1'b0;
        for (int c = 0; c < 500 && !reached; c++) begin
            @(negedge clock); #1;
            reached = (r_cnt >= 5) && r_ready;
        end
        if (!reached) abort("wait_mid_burst");
        #1 reset = 1'b1;
        #1;
        check("rst_arvalid", ar_valid, 1'b0);
        check("rst_rready", r_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        exp_w.delete();
        exp_ar.delete();
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0; r_id = '0; r_last = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_arvalid", ar_valid, 1'b0);
        check("reset_rready", r_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);

        run_cmd(32'h8000_0000, 4, 1'b1, -1, -1, 1'b0);
        run_cmd(32'h8000_0000, 40, 1'b0, -1, -1, 1'b0);
        run_cmd(32'h8000_0FF8, 6, 1'b0, -1, -1, 1'b0);
        run_cmd(32'h8000_2000, 64, 1'b0, -1, -1, 1'b1);
        run_cmd(32'h8000_3000, 8, 1'b0, 1, -1, 1'b0);
        run_cmd(32'h8000_3100, 8, 1'b0, -1, 0, 1'b0);
        run_cmd(32'h8000_3200, 5, 1'b1, -1, -1, 1'b0);
        run_cmd(32'h8000_3300, 0, 1'b0, -1, -1, 1'b0);
        reset_mid_burst();
        run_cmd(32'h8000_5000, 20, 1'b0, -1, -1, 1'b0);

        for (int t = 0; t < 12; t++) begin
            logic [31:0] a;
            int len, rr;
            a   = 32'h8000_0000 | ($urandom & 32'h0000_3FFF);
            if ($urandom_range(0, 1) == 1) a = a | 32'h0000_0FC0;
            len = $urandom_range(0, 70);
            rr  = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
            run_cmd(a, len, 1'($urandom_range(0, 1)), rr, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
